// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Glyph encoding is active-high with seg[0]=a .. seg[6]=g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } state_e;

    localparam logic [1:0] SLOT_SS_LO = 2'd0;
    localparam logic [1:0] SLOT_SS_HI = 2'd1;
    localparam logic [1:0] SLOT_MM_LO = 2'd2;
    localparam logic [1:0] SLOT_MM_HI = 2'd3;

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// BCD to 7-segment glyph decoder (combinational).
// Ports:
//   bcd   in  4  BCD nibble
//   glyph out 7  active-high segment pattern, dash for values above 9
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    // Nibble to glyph lookup; non-decimal codes show a dash.
    always_comb begin
        glyph = SEG_DASH;
        case (bcd)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-segment display scanner for the countdown timer.
// Scans one digit per slot, latches the BCD bus once per frame, lights the
// mm:ss separator and flashes the display after a finish event.
// Ports:
//   clk      in   1   system clock
//   reset    in   1   synchronous active-high reset
//   display  in  16   {mm_hi, mm_lo, ss_hi, ss_lo} BCD digits
//   finish   in   1   start/restart the flash sequence (level or pulse)
//   blank_lz in   1   blank mm_hi when it is zero
//   seg      out  7   segment pins (registered, polarity per SEG_ACTIVE_LOW)
//   dp       out  1   separator pin (registered, polarity per SEG_ACTIVE_LOW)
//   digit_en out  4   digit select pins (registered, polarity per DIG_ACTIVE_LOW)
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 10,
    parameter int DEAD_CYC       = 4,
    parameter int BLINK_FRAMES   = 64,
    parameter int FLASH_COUNT    = 6,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] display,
    input  logic        finish,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  digit_en
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int FW = (FLASH_COUNT  > 1) ? $clog2(FLASH_COUNT)  : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_COUNT - 1);
    localparam logic [SCAN_DIV-1:0] DEAD_LIM = SCAN_DIV'(DEAD_CYC);
    localparam logic [6:0] SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_POL  = (SEG_ACTIVE_LOW != 0) ? 1'b1  : 1'b0;
    localparam logic [3:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;

    logic [SCAN_DIV-1:0] pre_cnt_r;
    logic [1:0]          slot_r;
    logic [15:0]         snapshot_r;
    state_e              state_r;
    logic [BW-1:0]       blink_cnt_r;
    logic [FW-1:0]       flash_cnt_r;

    logic                wrap_s;
    logic                frame_end_s;
    logic [3:0]          nibble_s;
    logic [6:0]          glyph_s;
    logic                lit_s;
    logic [6:0]          seg_s;
    logic                dp_s;
    logic [3:0]          digit_s;
    state_e              state_nx_s;
    logic [BW-1:0]       blink_nx_s;
    logic [FW-1:0]       flash_nx_s;

    assign wrap_s      = (pre_cnt_r == {SCAN_DIV{1'b1}});
    assign frame_end_s = wrap_s && (slot_r == SLOT_MM_HI);

    // Select the snapshot nibble belonging to the current slot.
    always_comb begin
        nibble_s = 4'd0;
        case (slot_r)
            SLOT_SS_LO: nibble_s = snapshot_r[3:0];
            SLOT_SS_HI: nibble_s = snapshot_r[7:4];
            SLOT_MM_LO: nibble_s = snapshot_r[11:8];
            SLOT_MM_HI: nibble_s = snapshot_r[15:12];
            default:    nibble_s = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd   (nibble_s),
        .glyph (glyph_s)
    );

    // Active-high pin values: a digit is lit only when visible, past the
    // dead time, and not a suppressed leading zero.
    always_comb begin
        lit_s = 1'b0;
        if ((state_r != FLASH_OFF) && (pre_cnt_r >= DEAD_LIM) &&
            !((slot_r == SLOT_MM_HI) && blank_lz && (nibble_s == 4'd0))) begin
            lit_s = 1'b1;
        end else begin
            lit_s = 1'b0;
        end
        seg_s   = lit_s ? glyph_s : SEG_BLANK;
        dp_s    = lit_s && (slot_r == SLOT_MM_LO);
        digit_s = lit_s ? (4'b0001 << slot_r) : 4'b0000;
    end

    // Flash sequencer next state; finish overrides any frame-boundary step.
    always_comb begin
        state_nx_s = state_r;
        blink_nx_s = blink_cnt_r;
        flash_nx_s = flash_cnt_r;
        if (finish) begin
            state_nx_s = FLASH_OFF;
            blink_nx_s = '0;
            flash_nx_s = '0;
        end else if (frame_end_s && (state_r != NORMAL)) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_nx_s = '0;
                if (flash_cnt_r == FLASH_LAST) begin
                    state_nx_s = NORMAL;
                    flash_nx_s = '0;
                end else begin
                    flash_nx_s = flash_cnt_r + FW'(1);
                    state_nx_s = (state_r == FLASH_OFF) ? FLASH_ON : FLASH_OFF;
                end
            end else begin
                blink_nx_s = blink_cnt_r + BW'(1);
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // Prescaler, slot counter, frame snapshot and flash sequencer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_r   <= '0;
            slot_r      <= SLOT_SS_LO;
            snapshot_r  <= 16'h0000;
            state_r     <= NORMAL;
            blink_cnt_r <= '0;
            flash_cnt_r <= '0;
        end else begin
            pre_cnt_r   <= pre_cnt_r + SCAN_DIV'(1);
            slot_r      <= wrap_s ? slot_r + 2'd1 : slot_r;
            snapshot_r  <= frame_end_s ? display : snapshot_r;
            state_r     <= state_nx_s;
            blink_cnt_r <= blink_nx_s;
            flash_cnt_r <= flash_nx_s;
        end
    end

    // Output pin registers with board polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg      <= SEG_POL;
            dp       <= DP_POL;
            digit_en <= DIG_POL;
        end else begin
            seg      <= seg_s ^ SEG_POL;
            dp       <= dp_s ^ DP_POL;
            digit_en <= digit_s ^ DIG_POL;
        end
    end

endmodule
